// File: rtl/gpio_cond_pkg.sv
// Shared constants and helpers for the GPIO switch input conditioner.
package gpio_cond_pkg;

    localparam int DEFAULT_TICK_DIV     = 100000;
    localparam int DEFAULT_STABLE_TICKS = 10;

    // Width of a per-bit debounce counter that must hold 0..stable_ticks.
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch bit: two-flop synchronizer followed by a tick-qualified debounce filter.
// 'accept' is the combinational next-state of 'change'. The top level uses it so
// that event_pending updates in the same clock edge as sw_stable.
module debounce_channel
    import gpio_cond_pkg::*;
#(
    parameter int   STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter logic RESET_BIT    = 1'b0
) (
    input  logic gclk,
    input  logic grst_n,
    input  logic raw,
    input  logic tick,
    output logic accept,
    output logic stable,
    output logic change
);

    localparam int             CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          differ;

    assign differ = (sync_q[1] != stable);
    assign accept = tick && differ && (cnt == CNT_LAST);

    // Metastability guard: shift the raw pin through two flops.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) sync_q <= {2{RESET_BIT}};
        else         sync_q <= {sync_q[0], raw};
    end

    // Accept a new level only after STABLE_TICKS ticks of unbroken disagreement.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            cnt    <= '0;
            stable <= RESET_BIT;
            change <= 1'b0;
        end else begin
            change <= accept;
            if (!differ) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync_q[1];
                cnt    <= '0;
            end else if (tick) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_input_conditioner.sv
// Switch input conditioner: shared tick prescaler, per-bit debounce channels,
// sticky W1C event flags and a masked, registered interrupt.
module gpio_input_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int               STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             io_mainClk,
    input  logic             io_asyncReset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_change,
    output logic [WIDTH-1:0] event_pending,
    input  logic [WIDTH-1:0] event_clear,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);

    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] pend_nxt;

    // With TICK_DIV = 1 the counter sits at 0 == PRE_LAST, so tick is constant 1.
    assign tick = (pre_cnt == PRE_LAST);

    // Free-running prescaler, wraps after TICK_DIV cycles.
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) pre_cnt <= '0;
        else if (tick)        pre_cnt <= '0;
        else                  pre_cnt <= pre_cnt + PW'(1);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_BIT    (RESET_VALUE[i])
        ) u_ch (
            .gclk   (io_mainClk),
            .grst_n (io_asyncReset_n),
            .raw    (sw_raw[i]),
            .tick   (tick),
            .accept (accept[i]),
            .stable (sw_stable[i]),
            .change (sw_change[i])
        );
    end

    // A new event in the same cycle as a clear wins, so no edge is ever lost.
    always_comb begin
        pend_nxt = (event_pending & ~event_clear) | accept;
    end

    // Sticky flags and interrupt, both taken from the next-state flags.
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            event_pending <= '0;
            irq           <= 1'b0;
        end else begin
            event_pending <= pend_nxt;
            irq           <= |(pend_nxt & irq_mask);
        end
    end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: dut_a (TICK_DIV=1, STABLE_TICKS=3) and
// dut_b (TICK_DIV=4, STABLE_TICKS=3) checked against a timeline-based model.
module tb_gpio_input_conditioner;

    localparam int ST = 3;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic [7:0] raw_a = 8'h00, clr_a = 8'h00, mask_a = 8'hFF;
    logic [7:0] raw_b = 8'h00, clr_b = 8'h00, mask_b = 8'hFF;
    logic [7:0] a_stable, a_change, a_pend;
    logic [7:0] b_stable, b_change, b_pend;
    logic       a_irq, b_irq;

    int tests = 0;
    int fails = 0;

    always #10 clk = ~clk;

    gpio_input_conditioner #(.WIDTH(8), .TICK_DIV(1), .STABLE_TICKS(ST)) dut_a (
        .io_mainClk(clk), .io_asyncReset_n(rst_a), .sw_raw(raw_a),
        .sw_stable(a_stable), .sw_change(a_change), .event_pending(a_pend),
        .event_clear(clr_a), .irq_mask(mask_a), .irq(a_irq));

    gpio_input_conditioner #(.WIDTH(8), .TICK_DIV(4), .STABLE_TICKS(ST)) dut_b (
        .io_mainClk(clk), .io_asyncReset_n(rst_b), .sw_raw(raw_b),
        .sw_stable(b_stable), .sw_change(b_change), .event_pending(b_pend),
        .event_clear(clr_b), .irq_mask(mask_b), .irq(b_irq));

    // Reference model. Clock edges are numbered k = 0,1,.. from reset release;
    // the filter at edge k sees the raw value sampled at edge k-2, ticks fall on
    // edges with k % td == td-1, and a bit flips on the ST-th tick counted from
    // the first edge of an unbroken disagreement.
    logic [7:0] m_stable[2], m_chg[2], m_pend[2], m_q1[2], m_q2[2];
    logic       m_irq[2];
    int         m_k[2];
    int         m_since[2][8];
    int         rst_a_pulses = 0;
    int         seen_a = 0;

    task automatic model_reset(input int d);
        m_stable[d] = 8'h00; m_chg[d] = 8'h00; m_pend[d] = 8'h00;
        m_q1[d] = 8'h00; m_q2[d] = 8'h00; m_irq[d] = 1'b0; m_k[d] = 0;
        for (int i = 0; i < 8; i++) m_since[d][i] = -1;
    endtask

    task automatic model_step(input int d, input int td,
                              input logic [7:0] raw, input logic [7:0] clr, input logic [7:0] mask);
        logic [7:0] s, chg;
        int ticks;
        s = m_q2[d];
        m_q2[d] = m_q1[d];
        m_q1[d] = raw;
        chg = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (s[i] == m_stable[d][i]) begin
                m_since[d][i] = -1;
            end else begin
                if (m_since[d][i] < 0) m_since[d][i] = m_k[d];
                ticks = (m_k[d] + 1) / td - m_since[d][i] / td;
                if ((m_k[d] % td == td - 1) && ticks == ST) begin
                    chg[i] = 1'b1;
                    m_since[d][i] = -1;
                end
            end
        end
        m_stable[d] = m_stable[d] ^ chg;
        m_chg[d]    = chg;
        m_pend[d]   = (m_pend[d] & ~clr) | chg;
        m_irq[d]    = |(m_pend[d] & mask);
        m_k[d]      = m_k[d] + 1;
    endtask

    always @(negedge rst_a) rst_a_pulses = rst_a_pulses + 1;

    // A reset pulse that falls between two edges is replayed at the next edge.
    always @(posedge clk) begin
        if (!rst_a) begin
            model_reset(0);
            seen_a = rst_a_pulses;
        end else begin
            if (seen_a != rst_a_pulses) begin
                model_reset(0);
                seen_a = rst_a_pulses;
            end
            model_step(0, 1, raw_a, clr_a, mask_a);
        end
        if (!rst_b) model_reset(1);
        else        model_step(1, 4, raw_b, clr_b, mask_b);
    end

    task automatic test_reset;
        logic [7:0] exp_s;
        raw_a = 8'hFF;
        @(posedge clk); #1;
        tests++; if (a_stable !== 8'h00) begin fails++; $display("FAIL reset_stable: got %h expected 00", a_stable); end
        tests++; if (a_change !== 8'h00) begin fails++; $display("FAIL reset_change: got %h expected 00", a_change); end
        tests++; if (a_pend !== 8'h00) begin fails++; $display("FAIL reset_pending: got %h expected 00", a_pend); end
        tests++; if (a_irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", a_irq); end
        rst_a = 1'b1;
        // Edge n=1 is the first one to sample sw_raw; the level lands on edge 5.
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            exp_s = (n >= 5) ? 8'hFF : 8'h00;
            tests++; if (a_stable !== exp_s) begin fails++; $display("FAIL reset_latency edge %0d: got %h expected %h", n, a_stable, exp_s); end
            if (n == 5) begin
                tests++; if (a_change !== 8'hFF) begin fails++; $display("FAIL reset_change_pulse: got %h expected ff", a_change); end
                tests++; if (a_pend !== 8'hFF) begin fails++; $display("FAIL reset_pending_set: got %h expected ff", a_pend); end
            end
            if (n == 6) begin
                tests++; if (a_change !== 8'h00) begin fails++; $display("FAIL reset_change_end: got %h expected 00", a_change); end
            end
        end
    endtask

    task automatic test_multi_bit;
        raw_a = 8'h00;
        repeat (6) @(posedge clk);
        #1; clr_a = 8'hFF;
        @(posedge clk); #1;
        clr_a = 8'h00; raw_a = 8'hA5;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (n < 5 || n == 6) begin
                tests++; if (a_change !== 8'h00) begin fails++; $display("FAIL multi_change_quiet edge %0d: got %h expected 00", n, a_change); end
            end else begin
                tests++; if (a_change !== 8'hA5) begin fails++; $display("FAIL multi_change_pulse: got %h expected a5", a_change); end
            end
        end
        tests++; if (a_pend !== 8'hA5) begin fails++; $display("FAIL multi_pending: got %h expected a5", a_pend); end
        tests++; if (a_stable !== 8'hA5) begin fails++; $display("FAIL multi_stable: got %h expected a5", a_stable); end
    endtask

    task automatic test_collision;
        clr_a = 8'hFF;
        @(posedge clk); #1;
        clr_a = 8'h00;
        raw_a[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1; clr_a[2] = 1'b1;
        @(posedge clk); #1;
        tests++; if (a_change[2] !== 1'b1) begin fails++; $display("FAIL collide_change: got %b expected 1", a_change[2]); end
        tests++; if (a_pend[2] !== 1'b1) begin fails++; $display("FAIL collide_set_wins: got %b expected 1", a_pend[2]); end
        clr_a = 8'h00;
        @(posedge clk); #1;
        tests++; if (a_pend[2] !== 1'b1) begin fails++; $display("FAIL collide_hold: got %b expected 1", a_pend[2]); end
        clr_a[2] = 1'b1;
        @(posedge clk); #1;
        tests++; if (a_pend[2] !== 1'b0) begin fails++; $display("FAIL collide_clear: got %b expected 0", a_pend[2]); end
        clr_a = 8'h00;
    endtask

    task automatic test_irq_mask;
        clr_a = 8'hFF; mask_a = 8'hEF; raw_a[4] = 1'b1;
        @(posedge clk); #1;
        clr_a = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        tests++; if (a_pend !== 8'h10) begin fails++; $display("FAIL irq_pending: got %h expected 10", a_pend); end
        tests++; if (a_irq !== 1'b0) begin fails++; $display("FAIL irq_masked: got %b expected 0", a_irq); end
        mask_a = 8'hFF;
        @(posedge clk); #1;
        tests++; if (a_irq !== 1'b1) begin fails++; $display("FAIL irq_unmasked: got %b expected 1", a_irq); end
        clr_a[4] = 1'b1;
        @(posedge clk); #1;
        clr_a = 8'h00;
        tests++; if (a_pend !== 8'h00) begin fails++; $display("FAIL irq_clear_pending: got %h expected 00", a_pend); end
        tests++; if (a_irq !== 1'b0) begin fails++; $display("FAIL irq_after_clear: got %b expected 0", a_irq); end
    endtask

    task automatic test_async_reset;
        logic [7:0] exp_s;
        raw_a = 8'h0F;
        repeat (6) @(posedge clk);
        #1;
        tests++; if (a_stable !== 8'h0F) begin fails++; $display("FAIL areset_setup: got %h expected 0f", a_stable); end
        raw_a = 8'h2F;
        repeat (4) @(posedge clk);   // bit 5 counter now at 2 of 3
        #3; rst_a = 1'b0;
        #1;
        tests++; if (a_stable !== 8'h00) begin fails++; $display("FAIL areset_stable: got %h expected 00", a_stable); end
        tests++; if (a_pend !== 8'h00) begin fails++; $display("FAIL areset_pending: got %h expected 00", a_pend); end
        tests++; if (a_irq !== 1'b0) begin fails++; $display("FAIL areset_irq: got %b expected 0", a_irq); end
        tests++; if (a_change !== 8'h00) begin fails++; $display("FAIL areset_change: got %h expected 00", a_change); end
        #1; rst_a = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            exp_s = (n >= 5) ? 8'h2F : 8'h00;
            tests++; if (a_stable !== exp_s) begin fails++; $display("FAIL areset_requal edge %0d: got %h expected %h", n, a_stable, exp_s); end
        end
    endtask

    task automatic test_bounce;
        int pulses, rise;
        for (int c = 0; c < 60; c++) begin
            raw_b[0] = ((c / 6) % 2 == 0);
            @(posedge clk); #1;
            tests++; if (b_change[0] !== 1'b0) begin fails++; $display("FAIL bounce_no_pulse cyc %0d: got %b expected 0", c, b_change[0]); end
        end
        raw_b[0] = 1'b1;
        pulses = 0; rise = -1;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            if (b_change[0] === 1'b1) pulses++;
            if (rise < 0 && b_stable[0] === 1'b1) rise = n;
            tests++; if (b_stable !== m_stable[1]) begin fails++; $display("FAIL bounce_model edge %0d: got %h expected %h", n, b_stable, m_stable[1]); end
        end
        tests++; if (pulses != 1) begin fails++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
        tests++; if (rise < 1 || rise > 14) begin fails++; $display("FAIL bounce_rise: got edge %0d expected 1..14", rise); end
    endtask

    task automatic test_random(input int d, input int n);
        logic [7:0] r, c, m, gs, gc, gp;
        logic gi;
        int b;
        r = (d == 0) ? raw_a : raw_b;
        m = 8'hFF;
        for (int j = 0; j < n; j++) begin
            if ($urandom_range(5) == 0) begin
                b = $urandom_range(7);
                r[b] = ~r[b];
            end
            c = ($urandom_range(7) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(31) == 0) m = 8'($urandom);
            if (d == 0) begin raw_a = r; clr_a = c; mask_a = m; end
            else        begin raw_b = r; clr_b = c; mask_b = m; end
            @(posedge clk); #1;
            gs = (d == 0) ? a_stable : b_stable;
            gc = (d == 0) ? a_change : b_change;
            gp = (d == 0) ? a_pend   : b_pend;
            gi = (d == 0) ? a_irq    : b_irq;
            tests++;
            if ({gs, gc, gp, gi} !== {m_stable[d], m_chg[d], m_pend[d], m_irq[d]}) begin
                fails++;
                $display("FAIL random_dut%0d cyc %0d: got stable=%h change=%h pending=%h irq=%b, expected stable=%h change=%h pending=%h irq=%b",
                         d, j, gs, gc, gp, gi, m_stable[d], m_chg[d], m_pend[d], m_irq[d]);
            end
        end
        if (d == 0) clr_a = 8'h00; else clr_b = 8'h00;
    endtask

    initial begin
        @(posedge clk); #1;
        rst_b = 1'b1;
        test_reset();
        test_multi_bit();
        test_collision();
        test_irq_mask();
        test_async_reset();
        test_random(0, 600);
        test_bounce();
        test_random(1, 1500);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
Conditions the raw slide-switch inputs of the Arty35t Murax build before they reach the SoC GPIO read bus (io_gpioA_read[7:0]). Each bit passes through a two-flop synchronizer and a tick-based debounce filter. The block reports one-cycle change pulses and per-bit sticky event flags with software clear. A masked, level-sensitive interrupt output is provided for a spare GPIO read bit or a future interrupt line.

Parameters:
WIDTH, 8, number of switch channels
TICK_DIV, 100000, io_mainClk cycles per debounce tick (1 ms at 100 MHz); legal range >= 1
STABLE_TICKS, 10, consecutive ticks of disagreement required to accept a new level; legal range >= 1
RESET_VALUE, {WIDTH{1'b0}}, reset value of synchronizer flops and of sw_stable

Ports:
io_mainClk  input  1  system clock; all logic is in this one domain
io_asyncReset_n  input  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is assumed already synchronized upstream
sw_raw  input  WIDTH  asynchronous switch pins
sw_stable  output  WIDTH  debounced level, drives io_gpioA_read[WIDTH-1:0]
sw_change  output  WIDTH  one-cycle pulse per bit when sw_stable[i] toggles
event_pending  output  WIDTH  sticky flag per bit, set on any sw_stable toggle
event_clear  input  WIDTH  write-1-to-clear for event_pending, sampled every cycle
irq_mask  input  WIDTH  1 = bit contributes to irq
irq  output  1  registered OR of (event_pending & irq_mask)

Behaviour:
- Reset (io_asyncReset_n = 0, asynchronous):
  - sync flops = RESET_VALUE, sw_stable = RESET_VALUE.
  - sw_change = 0, event_pending = 0, irq = 0.
  - All debounce counters = 0, prescaler = 0.
  - Reset mid-debounce discards any partial count.
- Synchronizer: two flops per bit; sync2 is the filter input.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 for exactly one cycle when count == TICK_DIV-1.
  - TICK_DIV = 1 gives tick every cycle.
- Per-bit filter, counter width $clog2(STABLE_TICKS+1):
  - If sync2[i] == sw_stable[i]: cnt[i] <= 0. Any bounce back restarts the qualification.
  - Else if tick and cnt[i] == STABLE_TICKS-1: sw_stable[i] <= sync2[i], cnt[i] <= 0, sw_change[i] <= 1.
  - Else if tick: cnt[i] <= cnt[i]+1.
  - Otherwise hold.
  - sw_change[i] = 0 in all other cycles.
- Latency:
  - With TICK_DIV = 1, a clean raw edge appears on sw_stable 2+STABLE_TICKS cycles after the first clock edge that samples it.
  - In general, qualification takes between STABLE_TICKS-1 and STABLE_TICKS full tick periods, plus 2 cycles.
- event_pending[i]:
  - Set on the cycle sw_change[i] asserts, i.e. in the same register update as sw_stable.
  - Cleared by event_clear[i] = 1.
  - Simultaneous set and clear: set wins and the flag stays 1.
- irq: registered, updated every cycle from the next-state event_pending & irq_mask. Changing irq_mask affects irq one cycle later.
- All bits are independent. Multiple bits may toggle in the same cycle, and each pulses and flags separately.
- No combinational path from any input to any output.

Decomposition:
- Package gpio_cond_pkg holds:
  - Default constants DEFAULT_TICK_DIV = 100000 and DEFAULT_STABLE_TICKS = 10.
  - A function cnt_width(STABLE_TICKS) returning the counter width.
- Sub-module debounce_channel contains one bit's synchronizer, counter and stable/change register. It takes tick as an input.
- The top block instantiates:
  - The shared prescaler.
  - WIDTH copies of debounce_channel, via generate.
  - The pending/irq logic.

Test Plan:
- Reset default: hold io_asyncReset_n = 0 with sw_raw = 8'hFF. Require sw_stable = 8'h00, event_pending = 0, irq = 0. Deassert and run with TICK_DIV = 1, STABLE_TICKS = 3: sw_stable = 8'hFF exactly 5 cycles after the first sampling edge, sw_change = 8'hFF for 1 cycle, event_pending = 8'hFF.
- Bounce rejection: TICK_DIV = 4, STABLE_TICKS = 3. Toggle sw_raw[0] 0->1->0 every 6 cycles for 60 cycles, then hold 1. Require no sw_change[0] during the bounce. sw_stable[0] rises within 2+12 cycles of the final hold, with a single pulse.
- Clear vs set collision: force event_clear[2] = 1 on the same cycle sw_change[2] pulses. Require event_pending[2] = 1 afterwards. A later event_clear[2] = 1 takes it to 0 the next cycle.
- Masked irq: event_pending = 8'h10 with irq_mask = 8'hEF gives irq = 0. Set irq_mask = 8'hFF and irq = 1 one cycle later. Clear bit 4 and irq = 0 one cycle after the clear.
- Async reset mid-qualification: sw_raw[5] held high with cnt[5] = 2 of STABLE_TICKS = 3, then pulse io_asyncReset_n low for 1 ns between edges. Require immediate return of all outputs to reset values, and full requalification (2+3 cycles at TICK_DIV = 1) after release.
- Multi-bit simultaneity: sw_raw 8'h00 -> 8'hA5 in a single cycle. Require sw_change = 8'hA5 as one pulse and event_pending = 8'hA5.
